// File: rtl/etapa_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package etapa_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fifo_entry_t;

    // Restart addresses are always word aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/etapa_fetch_if.sv
// Instruction-memory request/acknowledge bus.
interface etapa_fetch_if;
    import etapa_fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [ILEN-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );

endinterface

// File: rtl/etapa_fetch_fifo.sv
// Instruction buffer between memory and decoder: FIFO with flush and occupancy count.
module fetch_fifo
    import etapa_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  fifo_entry_t      push_entry_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fifo_entry_t      head_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    fifo_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // A push is accepted when there is room, including room freed by a same-cycle pop.
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
    end

    // Pointer and occupancy bookkeeping; flush discards everything, including a same-cycle push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage, cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: issues word fetches, buffers returned words, handles redirects.
module etapa_fetch
    import etapa_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    etapa_fetch_if.master    imem,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    output logic             inst_valid_o,
    output logic [ILEN-1:0]  inst_o,
    output logic [XLEN-1:0]  inst_pc_o,
    input  logic             inst_ready_i
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e     state_q;
    logic             req_q;
    logic [XLEN-1:0]  fetch_pc_q;
    logic [XLEN-1:0]  drop_pc_q;

    logic             ack;
    logic             pop;
    logic             push;
    logic             flush;
    logic             head_valid;
    fifo_entry_t      head;
    fifo_entry_t      push_entry;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] occ_after_pop;
    logic [CNT_W-1:0] occ_after_push;
    logic [XLEN-1:0]  redirect_target;

    // Buffer control and occupancy look-ahead used by the FSM.
    always_comb begin
        ack             = imem.imem_ack;
        pop             = head_valid && inst_ready_i;
        flush           = redirect_i;
        push            = (state_q == ST_REQ) && ack && !redirect_i;
        push_entry      = '{pc: fetch_pc_q, inst: imem.imem_data};
        occ_after_pop   = count - CNT_W'(pop);
        occ_after_push  = occ_after_pop + CNT_W'(1);
        redirect_target = align_pc(redirect_pc_i);
    end

    // Fetch FSM; fetch_pc takes a redirect target immediately, while drop_pc keeps the
    // abandoned request's address on the bus until memory acknowledges it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            drop_pc_q  <= RESET_PC;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (redirect_i) begin
                        fetch_pc_q <= redirect_target;
                        state_q    <= ST_REQ;
                        req_q      <= 1'b1;
                    end else if (occ_after_pop < CNT_W'(FIFO_DEPTH)) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (redirect_i) begin
                        fetch_pc_q <= redirect_target;
                        if (!ack) begin
                            drop_pc_q <= fetch_pc_q;
                            state_q   <= ST_DROP;
                        end
                    end else if (ack) begin
                        fetch_pc_q <= fetch_pc_q + XLEN'(4);
                        if (occ_after_push >= CNT_W'(FIFO_DEPTH)) begin
                            state_q <= ST_IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    if (redirect_i) begin
                        fetch_pc_q <= redirect_target;
                    end
                    if (ack) begin
                        state_q <= ST_REQ;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = (state_q == ST_DROP) ? drop_pc_q : fetch_pc_q;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (flush),
        .head_o       (head),
        .valid_o      (head_valid),
        .count_o      (count)
    );

    assign inst_valid_o = head_valid;
    assign inst_o       = head_valid ? head.inst : '0;
    assign inst_pc_o    = head_valid ? head.pc   : '0;

endmodule

// File: tb/tb_etapa_fetch.sv
// Scoreboard bench for etapa_fetch: depth-4 instance for the main scenarios,
// depth-2 instance with a near-wrap reset PC for address wrap-around.
module tb_etapa_fetch;
    import etapa_fetch_pkg::*;

    localparam int unsigned     DEPTH_A  = 4;
    localparam logic [31:0]     RST_PC_B = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, rst_b_n;
    logic        redir_a, redir_b;
    logic [31:0] rpc_a, rpc_b;
    logic        valid_a, valid_b;
    logic [31:0] inst_a, inst_b, ipc_a, ipc_b;
    logic        ready_a, ready_b;

    etapa_fetch_if bus_a ();
    etapa_fetch_if bus_b ();

    etapa_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH_A)
    ) dut_a (
        .clk_i         (clk),
        .rst_ni        (rst_a_n),
        .imem          (bus_a),
        .redirect_i    (redir_a),
        .redirect_pc_i (rpc_a),
        .inst_valid_o  (valid_a),
        .inst_o        (inst_a),
        .inst_pc_o     (ipc_a),
        .inst_ready_i  (ready_a)
    );

    etapa_fetch #(
        .RESET_PC   (RST_PC_B),
        .FIFO_DEPTH (2)
    ) dut_b (
        .clk_i         (clk),
        .rst_ni        (rst_b_n),
        .imem          (bus_b),
        .redirect_i    (redir_b),
        .redirect_pc_i (rpc_b),
        .inst_valid_o  (valid_b),
        .inst_o        (inst_b),
        .inst_pc_o     (ipc_b),
        .inst_ready_i  (ready_b)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    fifo_entry_t sb_q[$];
    fifo_entry_t b_exp[$];
    logic [31:0] model_pc;
    logic [31:0] drop_addr;
    bit          model_drop;
    int unsigned lat;
    int unsigned wait_cnt;
    int unsigned pop_cnt;
    int unsigned p0;
    logic [31:0] last_pop_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One cycle of stimulus on instance A: memory responder, pop checking, model update.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
        fifo_entry_t e;
        bit          give_ack;
        @(negedge clk);
        ready_a  = rdy;
        redir_a  = redir;
        rpc_a    = rpc;
        give_ack = 1'b0;
        if (bus_a.imem_req) begin
            if (wait_cnt >= lat) begin
                give_ack = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        bus_a.imem_ack  = give_ack;
        bus_a.imem_data = give_ack ? mem_word(bus_a.imem_addr) : 32'hDEAD_BEEF;

        check32("valid_vs_model", {31'd0, valid_a}, {31'd0, sb_q.size() != 0});
        if (bus_a.imem_req)
            check32("imem_addr", bus_a.imem_addr, model_drop ? drop_addr : model_pc);
        if (valid_a && rdy && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check32("inst_pc", ipc_a, e.pc);
            check32("inst", inst_a, e.inst);
            pop_cnt++;
            last_pop_pc = ipc_a;
        end

        if (redir) begin
            sb_q.delete();
            if (give_ack) model_drop = 1'b0;
            else if (bus_a.imem_req && !model_drop) begin
                model_drop = 1'b1;
                drop_addr  = model_pc;
            end
            model_pc = rpc & ~32'h3;
        end else if (give_ack) begin
            if (model_drop) model_drop = 1'b0;
            else begin
                e.pc   = model_pc;
                e.inst = mem_word(model_pc);
                sb_q.push_back(e);
                model_pc = model_pc + 32'd4;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        fifo_entry_t eb;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        redir_a = 1'b0; redir_b = 1'b0;
        rpc_a = '0; rpc_b = '0;
        ready_a = 1'b0; ready_b = 1'b0;
        bus_a.imem_ack = 1'b0; bus_a.imem_data = '0;
        bus_b.imem_ack = 1'b0; bus_b.imem_data = '0;
        lat = 0; wait_cnt = 0; pop_cnt = 0;
        model_pc = 32'h0; drop_addr = 32'h0; model_drop = 1'b0;
        last_pop_pc = '1;

        repeat (2) @(negedge clk);
        check32("rst_req", {31'd0, bus_a.imem_req}, 32'd0);
        check32("rst_valid", {31'd0, valid_a}, 32'd0);
        check32("rst_inst", inst_a, 32'd0);
        check32("rst_inst_pc", ipc_a, 32'd0);
        check32("rst_addr", bus_a.imem_addr, 32'h0);
        check32("rst_b_addr", bus_b.imem_addr, RST_PC_B);
        check32("rst_b_req", {31'd0, bus_b.imem_req}, 32'd0);

        // Release reset: first cycle requests RESET_PC.
        @(negedge clk);
        rst_a_n = 1'b1;
        @(posedge clk); #1;
        check32("req_after_release", {31'd0, bus_a.imem_req}, 32'd1);
        check32("addr_after_release", bus_a.imem_addr, 32'h0);

        // Zero-wait streaming: one instruction per cycle after the first.
        repeat (22) step(1'b1, 1'b0, 32'h0);
        check32("stream_pops", pop_cnt, 32'd21);

        // Decoder stall: buffer fills to depth and requests stop.
        repeat (10) step(1'b0, 1'b0, 32'h0);
        check32("stall_fill", sb_q.size(), DEPTH_A);
        check32("stall_req_low", {31'd0, bus_a.imem_req}, 32'd0);
        repeat (12) step(1'b1, 1'b0, 32'h0);

        // Redirect coincident with ack and pop while two entries are buffered.
        step(1'b1, 1'b1, 32'h0000_0080);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check32("pre_redirect_occ", sb_q.size(), 32'd2);
        step(1'b1, 1'b1, 32'h0000_0040);
        step(1'b1, 1'b0, 32'h0);
        check32("redir_valid_low", {31'd0, valid_a}, 32'd0);
        check32("redir_req", {31'd0, bus_a.imem_req}, 32'd1);
        check32("redir_addr", bus_a.imem_addr, 32'h0000_0040);

        // Slow memory, redirect on wait cycle 1: old data dropped, restart at 0x100.
        lat = 3;
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0103);
        p0 = pop_cnt;
        for (int i = 0; i < 20 && pop_cnt == p0; i++) step(1'b1, 1'b0, 32'h0);
        check32("redir_first_pc", last_pop_pc, 32'h0000_0100);

        // Reset while an abandoned request is being drained.
        lat = 50;
        step(1'b1, 1'b1, 32'h0000_0300);
        step(1'b1, 1'b0, 32'h0);
        check32("drop_addr_held", bus_a.imem_addr, 32'h0000_0104);
        #2 rst_a_n = 1'b0;
        #1;
        check32("async_rst_req", {31'd0, bus_a.imem_req}, 32'd0);
        check32("async_rst_valid", {31'd0, valid_a}, 32'd0);
        check32("async_rst_inst", inst_a, 32'd0);
        check32("async_rst_inst_pc", ipc_a, 32'd0);
        check32("async_rst_addr", bus_a.imem_addr, 32'h0);
        sb_q.delete();
        model_pc = 32'h0; model_drop = 1'b0; wait_cnt = 0; lat = 0;
        @(negedge clk);
        rst_a_n = 1'b1;
        bus_a.imem_ack  = 1'b1;
        bus_a.imem_data = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        check32("stale_ack_req", {31'd0, bus_a.imem_req}, 32'd1);
        check32("stale_ack_addr", bus_a.imem_addr, 32'h0);
        check32("stale_ack_valid", {31'd0, valid_a}, 32'd0);
        p0 = pop_cnt;
        repeat (6) step(1'b1, 1'b0, 32'h0);
        check32("post_reset_pops", pop_cnt - p0, 32'd5);

        // Instance B: address wrap from 0xFFFF_FFFC to 0.
        eb.pc = 32'hFFFF_FFF8; eb.inst = mem_word(eb.pc); b_exp.push_back(eb);
        eb.pc = 32'hFFFF_FFFC; eb.inst = mem_word(eb.pc); b_exp.push_back(eb);
        eb.pc = 32'h0000_0000; eb.inst = mem_word(eb.pc); b_exp.push_back(eb);
        eb.pc = 32'h0000_0004; eb.inst = mem_word(eb.pc); b_exp.push_back(eb);
        bus_a.imem_ack = 1'b0;
        @(negedge clk);
        rst_b_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            ready_b = 1'b1;
            bus_b.imem_ack  = bus_b.imem_req;
            bus_b.imem_data = bus_b.imem_req ? mem_word(bus_b.imem_addr) : 32'h0;
            if (valid_b && b_exp.size() != 0) begin
                eb = b_exp.pop_front();
                check32("wrap_inst_pc", ipc_b, eb.pc);
                check32("wrap_inst", inst_b, eb.inst);
            end
        end
        check32("wrap_all_seen", b_exp.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
